// File: rtl/ram_port_ctrl.sv
// ram_port_ctrl
//   Single-port word RAM with byte-lane writes behind a valid/ready request
//   interface and a fixed-latency response pulse.
//
//   Parameters
//     ADDR_W  : word-address width, DEPTH = 2**ADDR_W words
//     DATA_W  : word width (multiple of 8), NB = DATA_W/8 byte lanes
//     LATENCY : cycles from acceptance edge to response (clamped to 1..4)
//
//   Ports
//     clk, rst         : rising-edge clock, synchronous active-high reset
//     req_valid/ready  : request handshake, accepted when both are high
//     req_write        : 1 = write, 0 = read
//     req_addr         : word address (taken modulo DEPTH)
//     req_wdata/req_be : write data and per-lane byte enables
//     rsp_valid        : one-cycle response pulse
//     rsp_rdata        : read data (zero for writes), held until next response
//     rsp_perr         : lane parity mismatch, valid with rsp_valid
//     dbg_flip_par     : test hook, inverts stored lane-0 parity on writes
//
//   Optional feature: define RAM_PORT_PARITY_EN to add one even-parity bit per
//   byte lane; without it rsp_perr is tied low and dbg_flip_par is ignored.
module ram_port_ctrl #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_be,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_perr,
    input  logic                  dbg_flip_par
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NB    = DATA_W / 8;
    localparam int LAT   = (LATENCY < 1) ? 1 : ((LATENCY > 4) ? 4 : LATENCY);
    localparam logic [1:0] CNT_INIT = (LAT >= 2) ? 2'(LAT - 2) : 2'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t              state;
    logic [1:0]          cnt;
    logic                accept;
    logic                wr_p1;
    logic [DATA_W-1:0]   rd_data_p1;
    logic [DATA_W-1:0]   resp_word;
    logic [DATA_W-1:0]   hold_q;

    // No reset on the array: contents survive rst, power-up value comes from
    // the device configuration.
    logic [DATA_W-1:0]   mem [DEPTH];

    assign req_ready = !rst && (state != WAIT);
    assign accept    = req_valid && req_ready;

    // ---- stage p0 -> p1: RAM access on the acceptance edge (read-first)
    always_ff @(posedge clk) begin
        if (accept) begin
            rd_data_p1 <= mem[req_addr];
            wr_p1      <= req_write;
            if (req_write) begin
                for (int i = 0; i < NB; i++) begin
                    if (req_be[i]) mem[req_addr][i*8 +: 8] <= req_wdata[i*8 +: 8];
                end
            end
        end
    end

    // ---- stage p1 -> response: latency FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= 2'd0;
            hold_q <= '0;
        end else begin
            if (state == RESP) hold_q <= resp_word;
            case (state)
                IDLE, RESP: begin
                    if (req_valid) begin
                        if (LAT == 1) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT: begin
                    if (cnt == 2'd0) state <= RESP;
                    else             cnt   <= cnt - 2'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign resp_word = wr_p1 ? '0 : rd_data_p1;
    assign rsp_valid = (state == RESP);
    // Live word during RESP, last response word otherwise.
    assign rsp_rdata = (state == RESP) ? resp_word : hold_q;

`ifdef RAM_PORT_PARITY_EN
    logic [NB-1:0] par_mem [DEPTH];
    logic [NB-1:0] par_p1;
    logic          perr_calc;

    always_ff @(posedge clk) begin
        if (accept) begin
            par_p1 <= par_mem[req_addr];
            if (req_write) begin
                for (int i = 0; i < NB; i++) begin
                    if (req_be[i])
                        par_mem[req_addr][i] <= (^req_wdata[i*8 +: 8]) ^ ((i == 0) && dbg_flip_par);
                end
            end
        end
    end

    always_comb begin
        perr_calc = 1'b0;
        for (int i = 0; i < NB; i++) begin
            perr_calc = perr_calc | ((^rd_data_p1[i*8 +: 8]) ^ par_p1[i]);
        end
    end

    assign rsp_perr = (state == RESP) && !wr_p1 && perr_calc;
`else
    logic unused_dbg;
    assign unused_dbg = dbg_flip_par;
    assign rsp_perr   = 1'b0;
`endif

endmodule

// File: tb/tb_ram_port_ctrl.sv
module tb_ram_port_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_write;
    logic [11:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        dbg_flip_par;

    logic        v1, v2, v4;
    logic        rdy1, rdy2, rdy4;
    logic        rv1, rv2, rv4;
    logic [31:0] rd1, rd2, rd4;
    logic        pe1, pe2, pe4;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ram_port_ctrl #(.ADDR_W(12), .DATA_W(32), .LATENCY(1)) u1 (
        .clk(clk), .rst(rst), .req_valid(v1), .req_ready(rdy1), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rv1), .rsp_rdata(rd1), .rsp_perr(pe1), .dbg_flip_par(dbg_flip_par));

    ram_port_ctrl #(.ADDR_W(12), .DATA_W(32), .LATENCY(2)) u2 (
        .clk(clk), .rst(rst), .req_valid(v2), .req_ready(rdy2), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rv2), .rsp_rdata(rd2), .rsp_perr(pe2), .dbg_flip_par(dbg_flip_par));

    ram_port_ctrl #(.ADDR_W(12), .DATA_W(32), .LATENCY(4)) u4 (
        .clk(clk), .rst(rst), .req_valid(v4), .req_ready(rdy4), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rv4), .rsp_rdata(rd4), .rsp_perr(pe4), .dbg_flip_par(dbg_flip_par));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic sel_valid(input int lat);
        case (lat)
            1:       return rv1;
            2:       return rv2;
            default: return rv4;
        endcase
    endfunction

    function automatic logic [31:0] sel_rdata(input int lat);
        case (lat)
            1:       return rd1;
            2:       return rd2;
            default: return rd4;
        endcase
    endfunction

    function automatic logic sel_perr(input int lat);
        case (lat)
            1:       return pe1;
            2:       return pe2;
            default: return pe4;
        endcase
    endfunction

    // One request on the instance with the given latency; checks that the
    // response pulse lands exactly lat cycles after acceptance and is single.
    task automatic issue(input string tag, input int lat, input logic wr, input logic [11:0] addr,
                         input logic [31:0] data, input logic [3:0] be, input logic flip,
                         output logic [31:0] rdata, output logic perr);
        req_write = wr; req_addr = addr; req_wdata = data; req_be = be; dbg_flip_par = flip;
        case (lat)
            1:       v1 = 1'b1;
            2:       v2 = 1'b1;
            default: v4 = 1'b1;
        endcase
        tick();
        v1 = 1'b0; v2 = 1'b0; v4 = 1'b0; dbg_flip_par = 1'b0;
        for (int k = 1; k < lat; k++) begin
            check({tag, "_early"}, 32'(sel_valid(lat)), 32'd0);
            tick();
        end
        check({tag, "_valid"}, 32'(sel_valid(lat)), 32'd1);
        rdata = sel_rdata(lat);
        perr  = sel_perr(lat);
        tick();
        check({tag, "_single"}, 32'(sel_valid(lat)), 32'd0);
        check({tag, "_hold"}, sel_rdata(lat), rdata);
    endtask

    logic [31:0] d;
    logic        p;
    logic [31:0] exp_perr;

    initial begin
        rst = 1'b1; v1 = 1'b0; v2 = 1'b0; v4 = 1'b0;
        req_write = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0; dbg_flip_par = 1'b0;
        tick(); tick();
        check("ready_in_rst", 32'(rdy2), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("idle_ready1", 32'(rdy1), 32'd1);
        check("idle_ready2", 32'(rdy2), 32'd1);
        check("idle_ready4", 32'(rdy4), 32'd1);
        check("idle_valid2", 32'(rv2), 32'd0);
        check("idle_rdata2", rd2, 32'd0);
        tick();

        // LATENCY = 2 write then read
        req_write = 1'b1; req_addr = 12'h005; req_wdata = 32'hDEADBEEF; req_be = 4'hF;
        v2 = 1'b1;
        tick();
        v2 = 1'b0;
        check("wait_not_ready", 32'(rdy2), 32'd0);
        check("wr_early", 32'(rv2), 32'd0);
        tick();
        check("wr_valid", 32'(rv2), 32'd1);
        check("wr_rdata_zero", rd2, 32'd0);
        tick();
        issue("rd5", 2, 1'b0, 12'h005, 32'h0, 4'h0, 1'b0, d, p);
        check("rd5_data", d, 32'hDEADBEEF);
        check("rd5_perr", 32'(p), 32'd0);

        // byte enables
        issue("wr10", 2, 1'b1, 12'h010, 32'h11223344, 4'hF, 1'b0, d, p);
        issue("wr10be", 2, 1'b1, 12'h010, 32'hAABBCCDD, 4'h5, 1'b0, d, p);
        issue("rd10", 2, 1'b0, 12'h010, 32'h0, 4'h0, 1'b0, d, p);
        check("rd10_data", d, 32'h11BB33DD);

        // be = 0 still responds, memory unchanged
        issue("wrbe0", 2, 1'b1, 12'h005, 32'h12345678, 4'h0, 1'b0, d, p);
        issue("rd5b", 2, 1'b0, 12'h005, 32'h0, 4'h0, 1'b0, d, p);
        check("rd5b_data", d, 32'hDEADBEEF);

        // address wraps modulo DEPTH: 12-bit port, so use top address
        issue("wrfff", 4, 1'b1, 12'hFFF, 32'h0BADF00D, 4'hF, 1'b0, d, p);
        issue("rdfff", 4, 1'b0, 12'hFFF, 32'h0, 4'h0, 1'b0, d, p);
        check("rdfff_data", d, 32'h0BADF00D);

        // LATENCY = 1 back-to-back
        for (int i = 0; i < 4; i++)
            issue("wr20", 1, 1'b1, 12'h020 + 12'(i), 32'hA0000000 + 32'(i), 4'hF, 1'b0, d, p);
        req_write = 1'b0; req_addr = 12'h020; v1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            req_addr = 12'h021 + 12'(i);
            if (i == 3) v1 = 1'b0;
            check("b2b_valid", 32'(rv1), 32'd1);
            check("b2b_ready", 32'(rdy1), 32'd1);
            check("b2b_data", rd1, 32'hA0000000 + 32'(i));
        end
        tick();
        check("b2b_end", 32'(rv1), 32'd0);

        // LATENCY = 4 reset mid-operation
        issue("wr30", 4, 1'b1, 12'h030, 32'hCAFE0001, 4'hF, 1'b0, d, p);
        req_write = 1'b0; req_addr = 12'h030; v4 = 1'b1;
        tick();
        v4 = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_valid0", 32'(rv4), 32'd0);
        check("abort_rdata0", rd4, 32'd0);
        for (int i = 0; i < 4; i++) begin
            check("abort_quiet", 32'(rv4), 32'd0);
            tick();
        end
        issue("rd30", 4, 1'b0, 12'h030, 32'h0, 4'h0, 1'b0, d, p);
        check("rd30_data", d, 32'hCAFE0001);

        // parity injection
`ifdef RAM_PORT_PARITY_EN
        exp_perr = 32'd1;
`else
        exp_perr = 32'd0;
`endif
        issue("wrpar", 2, 1'b1, 12'h040, 32'h000000FF, 4'hF, 1'b1, d, p);
        check("wrpar_perr", 32'(p), 32'd0);
        issue("rdpar", 2, 1'b0, 12'h040, 32'h0, 4'h0, 1'b0, d, p);
        check("rdpar_data", d, 32'h000000FF);
        check("rdpar_perr", 32'(p), exp_perr);
        issue("wrclean", 2, 1'b1, 12'h040, 32'h000000FF, 4'hF, 1'b0, d, p);
        issue("rdclean", 2, 1'b0, 12'h040, 32'h0, 4'h0, 1'b0, d, p);
        check("rdclean_perr", 32'(p), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ram_port_ctrl.md
RAM_PORT_CTRL -- requirements
Module: ram_port_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 12, which is the word-address width; DEPTH = 2**ADDR_W words.
REQ-002 The block SHALL have parameter DATA_W, default 32, which is the word width and must be a multiple of 8; NB = DATA_W/8 byte lanes.
REQ-003 The block SHALL have parameter LATENCY, default 2, which is the number of cycles from request acceptance to response; legal range 1..4.
REQ-004 The block SHALL have port clk, input, 1 bit: the clock; all logic is rising-edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 The block SHALL have port req_valid, input, 1 bit: a request is present.
REQ-007 The block SHALL have port req_ready, output, 1 bit: the block can accept a request this cycle.
REQ-008 The block SHALL have port req_write, input, 1 bit: 1 = write, 0 = read.
REQ-009 The block SHALL have port req_addr, input, ADDR_W bits: word address.
REQ-010 The block SHALL have port req_wdata, input, DATA_W bits: write data.
REQ-011 The block SHALL have port req_be, input, NB bits: byte enables for writes; bit i gates bits [8i+7:8i].
REQ-012 The block SHALL have port rsp_valid, output, 1 bit: one-cycle response pulse.
REQ-013 The block SHALL have port rsp_rdata, output, DATA_W bits: read data, valid with rsp_valid.
REQ-014 The block SHALL have port rsp_perr, output, 1 bit: parity error flag, valid with rsp_valid.
REQ-015 The block SHALL have port dbg_flip_par, input, 1 bit: test-only; inverts the stored parity of lane 0 on writes.

Function
REQ-016 Storage SHALL be an internal DEPTH x DATA_W array inferred as block RAM, with no external RAM IP.
REQ-017 The block SHALL implement FSM states IDLE, WAIT and RESP.
REQ-018 req_ready SHALL be 1 in IDLE and RESP, and 0 in WAIT and during rst.
REQ-019 A request SHALL be accepted on the rising edge where req_valid && req_ready; on that edge the block captures req_write and req_addr.
REQ-020 A write SHALL commit on the acceptance edge, updating only the lanes with req_be[i] = 1; req_be = 0 leaves memory unchanged but still produces a response.
REQ-021 A read SHALL return the word at the captured address as it was before any write in the same cycle.
REQ-022 On acceptance, the FSM SHALL go to RESP if LATENCY = 1, else to WAIT with a counter loaded to LATENCY-2.
REQ-023 WAIT SHALL decrement the counter and go to RESP when the counter is 0.
REQ-024 rsp_valid SHALL be 1 for exactly the one cycle spent in RESP, i.e. LATENCY cycles after the acceptance edge.
REQ-025 rsp_rdata SHALL hold the read data for reads and all-zeros for writes, and SHALL hold its value until the next response.
REQ-026 Acceptance in RESP SHALL give back-to-back service; a new request arriving while a response is presented goes directly to WAIT/RESP; sustained throughput is one request per LATENCY cycles.
REQ-027 In RESP with no new request, the FSM SHALL return to IDLE.
REQ-028 A LATENCY value outside 1..4 SHALL be clamped to the nearest legal value.
REQ-029 Addresses SHALL be used modulo DEPTH; there is no out-of-range error.

Reset
REQ-030 Under rst the FSM SHALL go to IDLE, the counter to 0, rsp_valid to 0, rsp_rdata to 0 and rsp_perr to 0.
REQ-031 rst mid-operation SHALL abort the pending response (no rsp_valid) and SHALL keep any write already committed.
REQ-032 rst SHALL NOT clear memory contents; the array initialises to zero at configuration.

Configuration
REQ-033 With macro RAM_PORT_PARITY_EN defined, the block SHALL store one even-parity bit per byte lane, written with the lane data under req_be.
REQ-034 With RAM_PORT_PARITY_EN defined, reads SHALL recompute parity, and rsp_perr SHALL be 1 with rsp_valid if any lane mismatches.
REQ-035 With RAM_PORT_PARITY_EN defined, dbg_flip_par = 1 on a write SHALL store inverted lane-0 parity.
REQ-036 Without RAM_PORT_PARITY_EN, no parity storage SHALL exist, rsp_perr SHALL be tied 0, and dbg_flip_par SHALL be ignored.

Verification
REQ-037 Reset then idle: req_ready = 1, rsp_valid = 0, rsp_rdata = 0 from the first cycle after rst deasserts.
REQ-038 LATENCY = 2: write 0xDEADBEEF to address 0x005 with be = 0xF, then read 0x005 -> rsp_valid exactly 2 cycles after each acceptance, read data 0xDEADBEEF, rsp_perr = 0.
REQ-039 Byte enables: write 0x11223344 to 0x010, then write 0xAABBCCDD with be = 0x5, then read -> 0x11BB33DD.
REQ-040 Back-to-back reads with LATENCY = 1 and req_valid held high -> one rsp_valid per cycle, with data in address order.
REQ-041 Reset mid-op: with LATENCY = 4, assert rst 2 cycles after a read is accepted -> no rsp_valid; a read issued after reset returns the correct data.
REQ-042 With RAM_PORT_PARITY_EN: write 0x000000FF with dbg_flip_par = 1, then read -> rsp_perr = 1 with rsp_valid; a clean rewrite then read -> rsp_perr = 0.
